uart_bip_cmd_rx: RTL and testbench
==================================

// Module: uart_bip_cmd_rx
// PURPOSE
// - Receive side of the host<->BIP UART link: decodes bytes from uart_rx into commands for the BIP.
// - LOAD writes a program into BIP instruction memory; RUN free-runs the BIP to HLT; STEP advances it one cycle.
// - Sits between uart_rx (byte + done pulse) and bip_BIP (valid/reset) plus the instruction-memory write port.
// - Mirrors bip_uart_interface, which reports acc/instruction/pc back over uart_tx.
// PARAMETERS
// - N_DATA              8          UART byte width
// - NB_DATABIP          16         instruction word width (two bytes)
// - LOG2_N_INSMEM_ADDR  11         instruction memory address width
// - CMD_LOAD            8'h4C      'L'
// - CMD_RUN             8'h52      'R'
// - CMD_STEP            8'h53      'S'
// - TIMEOUT_CYCLES      1_000_000  max i_clk cycles between bytes inside a LOAD frame
// PORTS
// - i_clk        in   1                   system clock; all logic on rising edge
// - i_rst        in   1                   synchronous, active-high reset
// - i_data       in   N_DATA              received byte; valid only while i_rx_done=1
// - i_rx_done    in   1                   one-cycle pulse: i_data holds a new byte
// - i_bip_halt   in   1                   BIP has executed HLT (level)
// - o_mem_we     out  1                   instruction-memory write strobe (1 cycle)
// - o_mem_addr   out  LOG2_N_INSMEM_ADDR  write address
// - o_mem_data   out  NB_DATABIP          write data
// - o_bip_valid  out  1                   BIP clock enable (level in RUN, 1-cycle pulse on STEP)
// - o_bip_reset  out  1                   holds BIP in reset during LOAD
// - o_busy       out  1                   1 in any state except IDLE
// - o_error      out  1                   1-cycle pulse: bad opcode, zero length, or timeout
// BEHAVIOUR
// - Reset: state=IDLE; all outputs 0; address, length, byte and timeout counters cleared.
// - All outputs registered; every response is visible the cycle after the triggering i_rx_done.
// - States: IDLE, LEN_LO, LEN_HI, WORD_LO, WORD_HI, RUN.
// - IDLE + byte: CMD_LOAD -> LEN_LO and o_bip_reset=1; CMD_RUN -> RUN;
//   CMD_STEP -> 1-cycle o_bip_valid pulse, stay IDLE; any other byte -> o_error pulse, stay IDLE.
// - RUN and STEP are both suppressed while i_bip_halt=1 (no o_bip_valid).
// - LEN_LO/LEN_HI: 16-bit word count N, LSB first.
//   N==0 or N>2**LOG2_N_INSMEM_ADDR -> o_error, o_bip_reset=0, IDLE. Otherwise -> WORD_LO, addr=0.
// - WORD_LO latches the low byte. WORD_HI completes {hi,lo} into o_mem_data with o_mem_we=1 at o_mem_addr.
//   After each write the address increments and the remaining count decrements.
//   Count==0 after a write -> IDLE and o_bip_reset=0 (the BIP starts from pc=0).
// - Address never wraps: the length check caps the last address at 2**LOG2_N_INSMEM_ADDR-1.
// - Timeout: in LEN_*/WORD_*, the counter clears on every i_rx_done.
//   Reaching TIMEOUT_CYCLES -> o_error, IDLE, o_bip_reset=0; words already written stay in memory.
// - RUN: o_bip_valid=1 every cycle until i_bip_halt=1, then o_bip_valid=0 and IDLE next cycle.
//   Bytes received in RUN are dropped silently.
// - i_rx_done in the same cycle as a timeout expiry: the byte wins (counter clears, no error).
// - i_rst mid-LOAD or mid-RUN: immediate return to IDLE with reset values; no partial write strobe.
// STRUCTURE
// - Shared package bip_uart_pkg: CMD_* codes, state encoding, NB_DATABIP, N_DATA and
//   LOG2_N_INSMEM_ADDR (shared with bip_uart_interface).
// - Sub-module uart_rx_timeout: loadable cycle counter with clear and expire outputs.
// - FSM and datapath live in this file.
// TESTING
// - Reset, then send 'S' with halt=0 -> exactly one o_bip_valid cycle; o_busy stays 0.
// - 'L',02,00,34,12,78,56 -> we at addr 0 data 16'h1234, then addr 1 data 16'h5678.
//   o_bip_reset high from after 'L' until after the last byte, then IDLE.
// - 'R' -> o_bip_valid high continuously; raise i_bip_halt at cycle 50 -> valid low next cycle, state IDLE.
// - 'L',00,00 -> o_error pulse, no write, o_bip_reset back to 0.
//   Byte 8'h41 in IDLE -> o_error pulse, no other effect.
// - 'L',01,00,AA then silence of TIMEOUT_CYCLES (bench override 100) -> o_error, no write, IDLE.
// - Assert i_rst after the third byte of a 2-word LOAD -> all outputs 0 next cycle.
//   A following valid LOAD works from addr 0.

Source files
------------

// File: rtl/bip_uart_pkg.sv
// Shared definitions for the host<->BIP UART link: byte/word widths, command
// codes and the command receiver state encoding.
package bip_uart_pkg;

  localparam int unsigned N_DATA             = 8;
  localparam int unsigned NB_DATABIP         = 16;
  localparam int unsigned LOG2_N_INSMEM_ADDR = 11;
  localparam int unsigned N_INSMEM           = 1 << LOG2_N_INSMEM_ADDR;

  localparam logic [N_DATA-1:0] CMD_LOAD = 8'h4C;
  localparam logic [N_DATA-1:0] CMD_RUN  = 8'h52;
  localparam logic [N_DATA-1:0] CMD_STEP = 8'h53;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_WORD_LO,
    ST_WORD_HI,
    ST_RUN
  } state_e;

  function automatic logic is_load_state(input state_e s);
    return (s == ST_LEN_LO) || (s == ST_LEN_HI) ||
           (s == ST_WORD_LO) || (s == ST_WORD_HI);
  endfunction

endpackage

// File: rtl/uart_rx_timeout.sv
// Inter-byte watchdog: counts enabled cycles since the last clear and flags
// expiry once TIMEOUT_CYCLES have elapsed.
module uart_rx_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign o_expire = i_en && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_en && !o_expire) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_bip_cmd_rx.sv
// Host command decoder for the BIP: turns received UART bytes into program
// loads, free-run and single-step control of the processor.
module uart_bip_cmd_rx
  import bip_uart_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [N_DATA-1:0]             i_data,
  input  logic                          i_rx_done,
  input  logic                          i_bip_halt,
  output logic                          o_mem_we,
  output logic [LOG2_N_INSMEM_ADDR-1:0] o_mem_addr,
  output logic [NB_DATABIP-1:0]         o_mem_data,
  output logic                          o_bip_valid,
  output logic                          o_bip_reset,
  output logic                          o_busy,
  output logic                          o_error
);

  localparam int unsigned LEN_W = 2 * N_DATA;
  localparam int unsigned REM_W = LOG2_N_INSMEM_ADDR + 1;

  state_e state_q, state_d;

  logic [N_DATA-1:0]             len_lo_q, len_lo_d;
  logic [N_DATA-1:0]             word_lo_q, word_lo_d;
  logic [LOG2_N_INSMEM_ADDR-1:0] waddr_q, waddr_d;
  logic [REM_W-1:0]              rem_q, rem_d;

  logic                          mem_we_q, mem_we_d;
  logic [LOG2_N_INSMEM_ADDR-1:0] mem_addr_q, mem_addr_d;
  logic [NB_DATABIP-1:0]         mem_data_q, mem_data_d;
  logic                          bip_valid_q, bip_valid_d;
  logic                          bip_reset_q, bip_reset_d;
  logic                          busy_q, busy_d;
  logic                          error_q, error_d;

  logic             expire;
  logic [LEN_W-1:0] len_word;
  logic             len_ok;
  logic             loading;

  assign loading  = is_load_state(state_q);
  assign len_word = {i_data, len_lo_q};
  assign len_ok   = (len_word != '0) && (len_word <= LEN_W'(N_INSMEM));

  // Counter runs only inside a LOAD frame; any received byte restarts it.
  uart_rx_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clr    (i_rx_done || !loading),
    .i_en     (loading),
    .o_expire (expire)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      len_lo_q    <= '0;
      word_lo_q   <= '0;
      waddr_q     <= '0;
      rem_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      bip_valid_q <= 1'b0;
      bip_reset_q <= 1'b0;
      busy_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_lo_q    <= len_lo_d;
      word_lo_q   <= word_lo_d;
      waddr_q     <= waddr_d;
      rem_q       <= rem_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      bip_valid_q <= bip_valid_d;
      bip_reset_q <= bip_reset_d;
      busy_q      <= busy_d;
      error_q     <= error_d;
    end
  end

  // A byte arriving in the expiry cycle is checked first, so it wins.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_rx_done) begin
          if (i_data == CMD_LOAD) begin
            state_d = ST_LEN_LO;
          end else if ((i_data == CMD_RUN) && !i_bip_halt) begin
            state_d = ST_RUN;
          end
        end
      end
      ST_LEN_LO: begin
        if (i_rx_done)   state_d = ST_LEN_HI;
        else if (expire) state_d = ST_IDLE;
      end
      ST_LEN_HI: begin
        if (i_rx_done)   state_d = len_ok ? ST_WORD_LO : ST_IDLE;
        else if (expire) state_d = ST_IDLE;
      end
      ST_WORD_LO: begin
        if (i_rx_done)   state_d = ST_WORD_HI;
        else if (expire) state_d = ST_IDLE;
      end
      ST_WORD_HI: begin
        if (i_rx_done)   state_d = (rem_q == REM_W'(1)) ? ST_IDLE : ST_WORD_LO;
        else if (expire) state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (i_bip_halt) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    len_lo_d  = len_lo_q;
    word_lo_d = word_lo_q;
    waddr_d   = waddr_q;
    rem_d     = rem_q;
    if (state_q == ST_IDLE) begin
      waddr_d = '0;
      rem_d   = '0;
    end
    if (i_rx_done) begin
      unique case (state_q)
        ST_LEN_LO:  len_lo_d = i_data;
        ST_LEN_HI: begin
          waddr_d = '0;
          rem_d   = len_word[REM_W-1:0];
        end
        ST_WORD_LO: word_lo_d = i_data;
        ST_WORD_HI: begin
          waddr_d = waddr_q + 1'b1;
          rem_d   = rem_q - 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    error_d     = 1'b0;
    bip_reset_d = is_load_state(state_d);
    busy_d      = (state_d != ST_IDLE);
    bip_valid_d = (state_d == ST_RUN) ||
                  ((state_q == ST_IDLE) && i_rx_done &&
                   (i_data == CMD_STEP) && !i_bip_halt);
    if ((state_q == ST_WORD_HI) && i_rx_done) begin
      mem_we_d   = 1'b1;
      mem_addr_d = waddr_q;
      mem_data_d = {i_data, word_lo_q};
    end
    if ((state_q == ST_IDLE) && i_rx_done &&
        (i_data != CMD_LOAD) && (i_data != CMD_RUN) && (i_data != CMD_STEP)) begin
      error_d = 1'b1;
    end
    if ((state_q == ST_LEN_HI) && i_rx_done && !len_ok) begin
      error_d = 1'b1;
    end
    if (loading && !i_rx_done && expire) begin
      error_d = 1'b1;
    end
  end

  assign o_mem_we    = mem_we_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_data  = mem_data_q;
  assign o_bip_valid = bip_valid_q;
  assign o_bip_reset = bip_reset_q;
  assign o_busy      = busy_q;
  assign o_error     = error_q;

endmodule

// File: tb/tb_uart_bip_cmd_rx.sv
// Directed bench for uart_bip_cmd_rx with a 100-cycle inter-byte timeout.
module tb_uart_bip_cmd_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  data;
  logic        rx_done;
  logic        halt;
  logic        mem_we;
  logic [10:0] mem_addr;
  logic [15:0] mem_data;
  logic        bip_valid;
  logic        bip_reset;
  logic        busy;
  logic        error;

  int n_checks = 0;
  int n_err    = 0;
  int we_cnt   = 0;
  int err_cnt  = 0;
  int val_cnt  = 0;

  uart_bip_cmd_rx #(.TIMEOUT_CYCLES(100)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_data      (data),
    .i_rx_done   (rx_done),
    .i_bip_halt  (halt),
    .o_mem_we    (mem_we),
    .o_mem_addr  (mem_addr),
    .o_mem_data  (mem_data),
    .o_bip_valid (bip_valid),
    .o_bip_reset (bip_reset),
    .o_busy      (busy),
    .o_error     (error)
  );

  always #5 clk = ~clk;

  always begin
    @(posedge clk);
    #1;
    if (mem_we)    we_cnt++;
    if (error)     err_cnt++;
    if (bip_valid) val_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Presents one byte for one cycle; returns at the negedge after it was consumed.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    data    = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    data    = 8'h00;
  endtask

  function automatic logic [31:0] all_outs();
    return {mem_we, mem_addr, mem_data, bip_valid, bip_reset, busy, error};
  endfunction

  initial begin
    int lows;
    int lat;
    int base_we;
    int base_err;
    int base_val;

    rst = 1'b1; data = 8'h00; rx_done = 1'b0; halt = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_outputs", all_outs(), 32'h0);

    // STEP
    send_byte(8'h53);
    chk("step_valid", {31'd0, bip_valid}, 32'd1);
    chk("step_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("step_valid_drop", {31'd0, bip_valid}, 32'd0);
    chk("step_valid_count", val_cnt, 32'd1);

    // LOAD two words
    send_byte(8'h4C);
    chk("load_reset_hi", {30'd0, bip_reset, busy}, 32'd3);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h34);
    chk("load_no_we_early", we_cnt, 32'd0);
    send_byte(8'h12);
    chk("load_w0", {mem_we, mem_addr, mem_data}, {4'd0, 1'b1, 11'd0, 16'h1234});
    chk("load_reset_mid", {31'd0, bip_reset}, 32'd1);
    @(negedge clk);
    chk("load_we_pulse", {31'd0, mem_we}, 32'd0);
    send_byte(8'h78);
    send_byte(8'h56);
    chk("load_w1", {mem_we, mem_addr, mem_data}, {4'd0, 1'b1, 11'd1, 16'h5678});
    chk("load_done", {29'd0, bip_reset, busy, error}, 32'd0);
    chk("load_we_count", we_cnt, 32'd2);

    // RUN until halt
    send_byte(8'h52);
    chk("run_start", {30'd0, bip_valid, busy}, 32'd3);
    lows = 0;
    for (int i = 0; i < 49; i++) begin
      @(negedge clk);
      if (!bip_valid) lows++;
    end
    chk("run_valid_level", lows, 32'd0);
    halt = 1'b1;
    @(negedge clk);
    chk("run_halt", {30'd0, bip_valid, busy}, 32'd0);
    base_val = val_cnt;
    send_byte(8'h53);
    chk("step_halted", {31'd0, bip_valid}, 32'd0);
    send_byte(8'h52);
    @(negedge clk);
    chk("run_halted", {30'd0, bip_valid, busy}, 32'd0);
    chk("halted_no_valid", val_cnt - base_val, 32'd0);
    halt = 1'b0;

    // Zero length and bad opcode
    base_we  = we_cnt;
    base_err = err_cnt;
    send_byte(8'h4C);
    send_byte(8'h00);
    send_byte(8'h00);
    chk("zero_len", {29'd0, bip_reset, busy, error}, 32'd1);
    @(negedge clk);
    chk("zero_len_pulse", {31'd0, error}, 32'd0);
    send_byte(8'h41);
    chk("bad_op", {29'd0, bip_reset, busy, error}, 32'd1);
    @(negedge clk);
    chk("err_count", err_cnt - base_err, 32'd2);
    chk("err_no_write", we_cnt - base_we, 32'd0);

    // Length bounds: 2049 rejected, 2048 accepted
    send_byte(8'h4C);
    send_byte(8'h01);
    send_byte(8'h08);
    chk("len_2049", {29'd0, bip_reset, busy, error}, 32'd1);
    send_byte(8'h4C);
    send_byte(8'h00);
    send_byte(8'h08);
    chk("len_2048", {29'd0, bip_reset, busy, error}, 32'd6);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("len_2048_rst", all_outs(), 32'h0);

    // Timeout
    base_we = we_cnt;
    send_byte(8'h4C);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'hAA);
    lat = 0;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (error) begin
        lat = i;
        break;
      end
    end
    chk("timeout_seen", {31'd0, (lat != 0)}, 32'd1);
    chk("timeout_latency", {31'd0, (lat >= 99 && lat <= 101)}, 32'd1);
    chk("timeout_idle", {30'd0, bip_reset, busy}, 32'd0);
    chk("timeout_no_write", we_cnt - base_we, 32'd0);

    // Byte in the expiry cycle wins
    base_err = err_cnt;
    send_byte(8'h4C);
    send_byte(8'h01);
    send_byte(8'h00);
    repeat (98) @(negedge clk);
    send_byte(8'hAA);
    chk("race_no_err", {29'd0, bip_reset, busy, error}, 32'd6);
    send_byte(8'hBB);
    chk("race_write", {mem_we, mem_addr, mem_data}, {4'd0, 1'b1, 11'd0, 16'hBBAA});
    chk("race_err_count", err_cnt - base_err, 32'd0);

    // Reset mid-LOAD, coinciding with the completing byte
    base_we = we_cnt;
    send_byte(8'h4C);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h11);
    @(negedge clk);
    data = 8'h22; rx_done = 1'b1; rst = 1'b1;
    @(negedge clk);
    data = 8'h00; rx_done = 1'b0; rst = 1'b0;
    chk("mid_load_rst", all_outs(), 32'h0);
    chk("mid_load_no_we", we_cnt - base_we, 32'd0);
    send_byte(8'h4C);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'hCD);
    send_byte(8'hAB);
    chk("reload_w0", {mem_we, mem_addr, mem_data}, {4'd0, 1'b1, 11'd0, 16'hABCD});
    chk("reload_done", {29'd0, bip_reset, busy, error}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
